// File: rtl/rpn_pkg.sv
// ---------------------------------------------------------------------------
// rpn_pkg
// Shared definitions for the RPN stack engine: operation codes and the
// operation FSM state encoding.
// ---------------------------------------------------------------------------
package rpn_pkg;

  localparam int OP_W = 3;

  // Operation codes presented on op_code; 3'd6 and 3'd7 are reserved.
  localparam logic [OP_W-1:0] OP_PUSH = 3'd0;
  localparam logic [OP_W-1:0] OP_POP  = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
  localparam logic [OP_W-1:0] OP_MULT = 3'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd4;
  localparam logic [OP_W-1:0] OP_CLR  = 3'd5;

  // Operation FSM: everything completes in IDLE except a two-operand MULT.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/rpn_seq_mult.sv
// ---------------------------------------------------------------------------
// rpn_seq_mult
// Iterative unsigned shift-add multiplier. One multiplier bit is consumed
// per clock, so a product takes DATA_W cycles after i_start.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (aborts any product)
//   i_start    in   load operands and begin a new product
//   i_a, i_b   in   DATA_W-bit unsigned operands, sampled with i_start
//   o_done     out  high during the final iteration cycle
//   o_product  out  2*DATA_W-bit product, valid while o_done is high
// ---------------------------------------------------------------------------
module rpn_seq_mult #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic                  o_done,
  output logic [2*DATA_W-1:0]   o_product
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [2*DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [2*DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic [2*DATA_W-1:0] w_acc_nxt;

  // Accumulator after folding in the current multiplier bit.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : {(2*DATA_W){1'b0}});

  // The last iteration's sum is handed out combinationally so the caller
  // can write it back on the DATA_W-th edge instead of one edge later.
  assign o_done    = r_busy & (r_cnt == CNT_W'(DATA_W - 1));
  assign o_product = w_acc_nxt;

  // Operand shift registers, accumulator and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= {(2*DATA_W){1'b0}};
      r_mplier <= {DATA_W{1'b0}};
      r_acc    <= {(2*DATA_W){1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{DATA_W{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= {(2*DATA_W){1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      r_busy   <= ~o_done;
    end else begin
      r_busy   <= 1'b0;
    end
  end

endmodule

// File: rtl/rpn_stack_engine.sv
// ---------------------------------------------------------------------------
// rpn_stack_engine
// Hardware RPN stack: PUSH, POP, ADD, SUB, iterative MULT and CLR on a
// DEPTH x DATA_W register stack, with stack- and arithmetic-overflow flags.
// Entry 0 is the top of stack; unused entries are always held at zero.
//
// Build option: define RPN_SAT_EN to saturate out-of-range results
// (ADD/MULT -> all ones, SUB -> 0); otherwise results wrap to DATA_W bits.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   op_valid/op_code    operation request (accepted when op_ready is high)
//   op_ready            low only while a two-operand MULT is in progress
//   din                 PUSH operand, sampled at accept
//   top, top_valid      stack[0] (0 when empty) and non-empty indication
//   size, size_led      occupancy count and its one-hot (bit size-1) form
//   stk_ovf, arith_ovf  overflow flags
// ---------------------------------------------------------------------------
module rpn_stack_engine
  import rpn_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int SIZE_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  output logic              op_ready,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] top,
  output logic              top_valid,
  output logic [SIZE_W-1:0] size,
  output logic [DEPTH-1:0]  size_led,
  output logic              stk_ovf,
  output logic              arith_ovf
);

`ifdef RPN_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef logic [DEPTH-1:0][DATA_W-1:0] stk_t;

  stk_t                r_stk, w_stk_nxt;
  logic [SIZE_W-1:0]   r_size, w_size_nxt;
  logic                r_stk_ovf, w_stk_ovf_nxt;
  logic                r_arith_ovf, w_arith_ovf_nxt;
  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_top;
  logic                r_top_valid;
  logic [DEPTH-1:0]    r_size_led;
  logic                r_op_ready;

  logic                w_accept;
  logic                w_empty, w_full, w_two;
  logic [DATA_W:0]     w_sum, w_diff;
  logic [DATA_W-1:0]   w_add_res, w_sub_res, w_mul_res;
  logic                w_mul_ovf, w_mul_start, w_mul_done;
  logic [2*DATA_W-1:0] w_mul_prod;

  // Shift everything up one slot and place the new value on top.
  function automatic stk_t f_push(input stk_t s, input logic [DATA_W-1:0] v);
    stk_t t;
    for (int i = DEPTH - 1; i > 0; i--) t[i] = s[i-1];
    t[0] = v;
    return t;
  endfunction

  // Drop the top entry; the bottom slot refills with zero.
  function automatic stk_t f_pop(input stk_t s);
    stk_t t;
    for (int i = 0; i < DEPTH - 1; i++) t[i] = s[i+1];
    t[DEPTH-1] = {DATA_W{1'b0}};
    return t;
  endfunction

  // Replace the two top operands by one result; entries from 2 up shift down.
  function automatic stk_t f_collapse(input stk_t s, input logic [DATA_W-1:0] res);
    stk_t t;
    t = f_pop(s);
    t[0] = res;
    return t;
  endfunction

  // One-hot occupancy: bit n-1 set for n entries, all clear when empty.
  function automatic logic [DEPTH-1:0] f_onehot(input logic [SIZE_W-1:0] n);
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = (n == SIZE_W'(i + 1));
    return v;
  endfunction

  assign w_accept = op_valid & r_op_ready;
  assign w_empty  = (r_size == {SIZE_W{1'b0}});
  assign w_full   = (r_size == SIZE_W'(DEPTH));
  assign w_two    = (r_size >= SIZE_W'(2));

  // Arithmetic on the two top entries; bit DATA_W is the carry / borrow.
  assign w_sum     = {1'b0, r_stk[0]} + {1'b0, r_stk[1]};
  assign w_diff    = {1'b0, r_stk[0]} - {1'b0, r_stk[1]};
  assign w_add_res = (w_sum[DATA_W] & SAT_EN)  ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
  assign w_sub_res = (w_diff[DATA_W] & SAT_EN) ? {DATA_W{1'b0}} : w_diff[DATA_W-1:0];
  assign w_mul_ovf = |w_mul_prod[2*DATA_W-1:DATA_W];
  assign w_mul_res = (w_mul_ovf & SAT_EN) ? {DATA_W{1'b1}} : w_mul_prod[DATA_W-1:0];

  rpn_seq_mult #(.DATA_W(DATA_W)) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (r_stk[0]),
    .i_b       (r_stk[1]),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

  // Next stack contents, occupancy, flags and FSM state.
  always_comb begin
    w_stk_nxt       = r_stk;
    w_size_nxt      = r_size;
    w_stk_ovf_nxt   = r_stk_ovf;
    w_arith_ovf_nxt = r_arith_ovf;
    w_state_nxt     = r_state;
    w_mul_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (op_code)
            OP_PUSH: begin
              // Any accepted PUSH starts a fresh arithmetic context.
              w_arith_ovf_nxt = 1'b0;
              if (w_full) begin
                w_stk_ovf_nxt = 1'b1;
              end else begin
                w_stk_nxt     = f_push(r_stk, din);
                w_size_nxt    = r_size + SIZE_W'(1);
                w_stk_ovf_nxt = 1'b0;
              end
            end
            OP_POP: begin
              if (!w_empty) begin
                w_stk_nxt     = f_pop(r_stk);
                w_size_nxt    = r_size - SIZE_W'(1);
                w_stk_ovf_nxt = 1'b0;
              end else begin
                w_size_nxt    = r_size;
              end
            end
            OP_ADD, OP_SUB: begin
              if (w_two) begin
                w_stk_nxt       = f_collapse(r_stk, (op_code == OP_ADD) ? w_add_res : w_sub_res);
                w_size_nxt      = r_size - SIZE_W'(1);
                w_arith_ovf_nxt = (op_code == OP_ADD) ? w_sum[DATA_W] : w_diff[DATA_W];
                w_stk_ovf_nxt   = 1'b0;
              end else begin
                w_size_nxt      = r_size;
              end
            end
            OP_MULT: begin
              if (w_two) begin
                w_mul_start = 1'b1;
                w_state_nxt = ST_MUL;
              end else if (!w_empty) begin
                // Single operand: product with the missing operand is 0.
                w_stk_nxt[0]    = {DATA_W{1'b0}};
                w_arith_ovf_nxt = 1'b0;
              end else begin
                w_size_nxt      = r_size;
              end
            end
            OP_CLR: begin
              w_stk_nxt       = {DEPTH{{DATA_W{1'b0}}}};
              w_size_nxt      = {SIZE_W{1'b0}};
              w_stk_ovf_nxt   = 1'b0;
              w_arith_ovf_nxt = 1'b0;
            end
            default: begin
              w_size_nxt = r_size;
            end
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_stk_nxt       = f_collapse(r_stk, w_mul_res);
          w_size_nxt      = r_size - SIZE_W'(1);
          w_arith_ovf_nxt = w_mul_ovf;
          w_stk_ovf_nxt   = 1'b0;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_state_nxt     = ST_MUL;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State registers plus display outputs derived from the next-state values
  // so top/top_valid/size_led always agree with size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stk       <= {DEPTH{{DATA_W{1'b0}}}};
      r_size      <= {SIZE_W{1'b0}};
      r_stk_ovf   <= 1'b0;
      r_arith_ovf <= 1'b0;
      r_state     <= ST_IDLE;
      r_top       <= {DATA_W{1'b0}};
      r_top_valid <= 1'b0;
      r_size_led  <= {DEPTH{1'b0}};
      r_op_ready  <= 1'b1;
    end else begin
      r_stk       <= w_stk_nxt;
      r_size      <= w_size_nxt;
      r_stk_ovf   <= w_stk_ovf_nxt;
      r_arith_ovf <= w_arith_ovf_nxt;
      r_state     <= w_state_nxt;
      r_top       <= (w_size_nxt != {SIZE_W{1'b0}}) ? w_stk_nxt[0] : {DATA_W{1'b0}};
      r_top_valid <= (w_size_nxt != {SIZE_W{1'b0}});
      r_size_led  <= f_onehot(w_size_nxt);
      r_op_ready  <= (w_state_nxt == ST_IDLE);
    end
  end

  assign op_ready  = r_op_ready;
  assign top       = r_top;
  assign top_valid = r_top_valid;
  assign size      = r_size;
  assign size_led  = r_size_led;
  assign stk_ovf   = r_stk_ovf;
  assign arith_ovf = r_arith_ovf;

endmodule

// File: tb/tb_rpn_stack_engine.sv
// ---------------------------------------------------------------------------
// tb_rpn_stack_engine
// Self-checking bench for rpn_stack_engine (DATA_W=8, DEPTH=8). A queue
// based stack model (front = top) predicts every result from the operation
// rules using plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_rpn_stack_engine;

  localparam int PUSH = 0, POP = 1, ADD = 2, MULT = 3, SUB = 4, CLR = 5;
  localparam int MAXV = 255;
`ifdef RPN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic [2:0] op_code;
  logic       op_ready;
  logic [7:0] din;
  logic [7:0] top;
  logic       top_valid;
  logic [3:0] size;
  logic [7:0] size_led;
  logic       stk_ovf;
  logic       arith_ovf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int q[$];
  bit m_stk_ovf, m_arith_ovf;
  int m_exp_busy;

  always #5 clk = ~clk;

  rpn_stack_engine #(.DATA_W(8), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .din(din), .top(top), .top_valid(top_valid),
    .size(size), .size_led(size_led), .stk_ovf(stk_ovf), .arith_ovf(arith_ovf)
  );

  function automatic void model_reset();
    q.delete();
    m_stk_ovf   = 1'b0;
    m_arith_ovf = 1'b0;
    m_exp_busy  = 0;
  endfunction

  // Apply one accepted operation to the model.
  function automatic void model_apply(input int opc, input int d);
    int a, b, r;
    bit ovf;
    m_exp_busy = 0;
    case (opc)
      PUSH: begin
        m_arith_ovf = 1'b0;
        if (q.size() < 8) begin q.push_front(d); m_stk_ovf = 1'b0; end
        else m_stk_ovf = 1'b1;
      end
      POP: if (q.size() > 0) begin void'(q.pop_front()); m_stk_ovf = 1'b0; end
      ADD, SUB, MULT: begin
        if (q.size() >= 2) begin
          a = q[0]; b = q[1];
          if (opc == ADD) begin r = a + b; ovf = (r > MAXV); if (ovf) r = SAT ? MAXV : (r % 256); end
          else if (opc == SUB) begin ovf = (b > a); r = ovf ? (SAT ? 0 : (a - b + 256)) : (a - b); end
          else begin r = a * b; ovf = (r > MAXV); if (ovf) r = SAT ? MAXV : (r % 256); m_exp_busy = 8; end
          void'(q.pop_front()); void'(q.pop_front()); q.push_front(r);
          m_arith_ovf = ovf; m_stk_ovf = 1'b0;
        end else if (opc == MULT && q.size() == 1) begin
          q[0] = 0; m_arith_ovf = 1'b0;
        end
      end
      CLR: begin q.delete(); m_stk_ovf = 1'b0; m_arith_ovf = 1'b0; end
      default: ;
    endcase
  endfunction

  // Present one op, hold it until accepted, update the model, then wait
  // until the engine is ready again. Returns the number of busy cycles.
  task automatic issue(input int opc, input int d, output int busy);
    int n;
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'(opc); din = 8'(d);
    n = 0;
    while (op_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      n_checks++; n_errors++;
      $display("FAIL issue_timeout: op_ready=%b required 1", op_ready);
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    model_apply(opc, d);
    busy = 0;
    while (op_ready !== 1'b1 && busy < 40) begin busy++; @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op_valid = 1'b0; op_code = 3'd0; din = 8'd0;
    model_reset();
    #12;
    n_checks++; if ({top, top_valid, size, size_led, stk_ovf, arith_ovf, op_ready} !== {8'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      n_errors++; $display("FAIL reset_state: top=%0d tv=%b size=%0d led=%h so=%b ao=%b rdy=%b required 0/0/0/00/0/0/1", top, top_valid, size, size_led, stk_ovf, arith_ovf, op_ready); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (size !== 4'd0 || op_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_release: size=%0d rdy=%b required 0/1", size, op_ready); end
  endtask

  task automatic test_add();
    int bz;
    issue(CLR, 0, bz); issue(PUSH, 3, bz); issue(PUSH, 5, bz); issue(ADD, 0, bz);
    n_checks++; if (top !== 8'd8 || size !== 4'd1 || size_led !== 8'h01 || arith_ovf !== 1'b0) begin
      n_errors++; $display("FAIL add_basic: top=%0d size=%0d led=%h ao=%b required 8/1/01/0", top, size, size_led, arith_ovf); end
    issue(POP, 0, bz);
    n_checks++; if (size !== 4'd0 || top_valid !== 1'b0 || top !== 8'd0) begin
      n_errors++; $display("FAIL pop_to_empty: size=%0d tv=%b top=%0d required 0/0/0", size, top_valid, top); end
  endtask

  task automatic test_add_ovf();
    int bz;
    logic [7:0] exp_top;
    exp_top = SAT ? 8'd255 : 8'd44;
    issue(PUSH, 200, bz); issue(PUSH, 100, bz); issue(ADD, 0, bz);
    n_checks++; if (top !== exp_top || arith_ovf !== 1'b1 || size !== 4'd1) begin
      n_errors++; $display("FAIL add_ovf: top=%0d ao=%b size=%0d required %0d/1/1", top, arith_ovf, size, exp_top); end
    issue(PUSH, 1, bz);
    n_checks++; if (arith_ovf !== 1'b0 || top !== 8'd1 || size !== 4'd2) begin
      n_errors++; $display("FAIL push_clears_ao: ao=%b top=%0d size=%0d required 0/1/2", arith_ovf, top, size); end
    issue(SUB, 0, bz);  // 1 - top-of-previous-result: borrow expected
    n_checks++; if (arith_ovf !== 1'b1 || top !== (SAT ? 8'd0 : 8'(1 - int'(exp_top) + 256))) begin
      n_errors++; $display("FAIL sub_borrow: ao=%b top=%0d required 1/%0d", arith_ovf, top, SAT ? 0 : (1 - int'(exp_top) + 256)); end
  endtask

  task automatic test_stack_ovf();
    int bz;
    issue(CLR, 0, bz);
    for (int i = 0; i < 8; i++) issue(PUSH, 9, bz);
    issue(PUSH, 7, bz);
    n_checks++; if (stk_ovf !== 1'b1 || size !== 4'd8 || top !== 8'd9 || size_led !== 8'h80) begin
      n_errors++; $display("FAIL stack_full: so=%b size=%0d top=%0d led=%h required 1/8/9/80", stk_ovf, size, top, size_led); end
    issue(POP, 0, bz);
    n_checks++; if (stk_ovf !== 1'b0 || size !== 4'd7 || size_led !== 8'h40) begin
      n_errors++; $display("FAIL pop_after_full: so=%b size=%0d led=%h required 0/7/40", stk_ovf, size, size_led); end
  endtask

  task automatic test_mult();
    int bz, n;
    logic [7:0] exp_top;
    exp_top = SAT ? 8'd255 : 8'd64;
    issue(CLR, 0, bz); issue(PUSH, 16, bz); issue(PUSH, 20, bz);
    @(negedge clk); op_valid = 1'b1; op_code = 3'(MULT); din = 8'd0;
    @(posedge clk); #1;
    model_apply(MULT, 0);
    op_code = 3'(PUSH); din = 8'd99;  // held while busy: must be ignored
    n = 0;
    while (op_ready !== 1'b1 && n < 40) begin
      n++;
      if (n == 3) begin
        n_checks++; if (size !== 4'd2 || top !== 8'd20) begin
          n_errors++; $display("FAIL mult_busy_hold: size=%0d top=%0d required 2/20", size, top); end
      end
      if (n == 5) op_valid = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++; if (n !== 8) begin
      n_errors++; $display("FAIL mult_busy_cycles: got %0d required 8", n); end
    n_checks++; if (top !== exp_top || size !== 4'd1 || arith_ovf !== 1'b1 || size_led !== 8'h01) begin
      n_errors++; $display("FAIL mult_result: top=%0d size=%0d ao=%b led=%h required %0d/1/1/01", top, size, arith_ovf, size_led, exp_top); end
    issue(PUSH, 12, bz); issue(PUSH, 11, bz); issue(MULT, 0, bz);
    n_checks++; if (top !== 8'd132 || arith_ovf !== 1'b0 || bz !== 8) begin
      n_errors++; $display("FAIL mult_in_range: top=%0d ao=%b busy=%0d required 132/0/8", top, arith_ovf, bz); end
  endtask

  task automatic test_edges();
    int bz;
    issue(CLR, 0, bz); issue(PUSH, 4, bz); issue(MULT, 0, bz);
    n_checks++; if (top !== 8'd0 || size !== 4'd1 || top_valid !== 1'b1 || bz !== 0) begin
      n_errors++; $display("FAIL mult_one_operand: top=%0d size=%0d tv=%b busy=%0d required 0/1/1/0", top, size, top_valid, bz); end
    issue(CLR, 0, bz); issue(PUSH, 200, bz); issue(PUSH, 100, bz); issue(ADD, 0, bz); issue(POP, 0, bz);
    issue(POP, 0, bz); issue(ADD, 0, bz); issue(MULT, 0, bz); issue(SUB, 0, bz); issue(6, 0, bz);
    n_checks++; if (size !== 4'd0 || arith_ovf !== 1'b1 || stk_ovf !== 1'b0 || top_valid !== 1'b0 || bz !== 0) begin
      n_errors++; $display("FAIL empty_noops: size=%0d ao=%b so=%b tv=%b busy=%0d required 0/1/0/0/0", size, arith_ovf, stk_ovf, top_valid, bz); end
  endtask

  task automatic test_reset_mid_mul();
    int bz;
    issue(CLR, 0, bz); issue(PUSH, 16, bz); issue(PUSH, 20, bz);
    @(negedge clk); op_valid = 1'b1; op_code = 3'(MULT);
    @(posedge clk); #1; op_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if ({top, top_valid, size, size_led, stk_ovf, arith_ovf, op_ready} !== {8'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      n_errors++; $display("FAIL reset_mid_mul: top=%0d tv=%b size=%0d led=%h so=%b ao=%b rdy=%b required 0/0/0/00/0/0/1", top, top_valid, size, size_led, stk_ovf, arith_ovf, op_ready); end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (size !== 4'd0 || top !== 8'd0 || op_ready !== 1'b1) begin
      n_errors++; $display("FAIL no_late_writeback: size=%0d top=%0d rdy=%b required 0/0/1", size, top, op_ready); end
    issue(PUSH, 1, bz);
    n_checks++; if (top !== 8'd1 || size !== 4'd1) begin
      n_errors++; $display("FAIL push_after_reset: top=%0d size=%0d required 1/1", top, size); end
  endtask

  task automatic test_random();
    int bz, r, opc, d, e_size, e_top, e_led;
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 15);
      if (r <= 5) opc = PUSH;
      else if (r <= 7) opc = POP;
      else if (r <= 9) opc = ADD;
      else if (r <= 11) opc = MULT;
      else if (r <= 13) opc = SUB;
      else if (r == 14) opc = CLR;
      else opc = $urandom_range(6, 7);
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
      issue(opc, d, bz);
      e_size = q.size();
      e_top  = (e_size > 0) ? q[0] : 0;
      e_led  = (e_size > 0) ? (1 << (e_size - 1)) : 0;
      n_checks++; if (size !== 4'(e_size) || top !== 8'(e_top) || top_valid !== (e_size > 0)) begin
        n_errors++; $display("FAIL rand_stack op=%0d: size=%0d top=%0d tv=%b required %0d/%0d/%b", opc, size, top, top_valid, e_size, e_top, e_size > 0); end
      n_checks++; if (size_led !== 8'(e_led) || stk_ovf !== m_stk_ovf || arith_ovf !== m_arith_ovf) begin
        n_errors++; $display("FAIL rand_flags op=%0d: led=%h so=%b ao=%b required %h/%b/%b", opc, size_led, stk_ovf, arith_ovf, e_led, m_stk_ovf, m_arith_ovf); end
      n_checks++; if (bz !== m_exp_busy) begin
        n_errors++; $display("FAIL rand_busy op=%0d: got %0d required %0d", opc, bz, m_exp_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_ovf();
    test_stack_ovf();
    test_mult();
    test_edges();
    test_reset_mid_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
